// File: rtl/noc_output_arbiter.sv
// Round-robin wormhole arbiter for one router output port.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module noc_output_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] tail,
  input  logic              out_ready,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  xbar_sel,
  output logic              fire,
  output logic              watchdog_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_IN-1:0] grant_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  ptr_nxt;
  logic [SEL_W-1:0]  ptr_inc;
  logic [SEL_W-1:0]  pick;
  logic [SEL_W-1:0]  pick_hi;
  logic [SEL_W-1:0]  pick_lo;
  logic              pick_hi_v;
  logic              tail_g;
  logic              release_g;
  logic              wd_hit;

  if (SEL_W < $clog2(NUM_IN)) begin : g_bad_sel
    $error("SEL_W too narrow for NUM_IN");
  end

  if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit stall counter");
  end

  assign fire    = (|(grant & req)) & out_ready;
  assign tail_g  = |(grant & tail);
  assign ptr_inc = (xbar_sel == SEL_W'(NUM_IN - 1))
                 ? '0
                 : xbar_sel + SEL_W'(1);

  // Lowest requester at or above rr_ptr wins, else lowest overall.
  always_comb begin
    pick_hi   = '0;
    pick_lo   = '0;
    pick_hi_v = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = SEL_W'(i);
        if (SEL_W'(i) >= rr_ptr) begin
          pick_hi   = SEL_W'(i);
          pick_hi_v = 1'b1;
        end
      end
    end
    pick = pick_hi_v ? pick_hi : pick_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      xbar_sel <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      xbar_sel <= sel_nxt;
      rr_ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = xbar_sel;
    ptr_nxt   = rr_ptr;
    release_g = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = NUM_IN'(1) << pick;
          sel_nxt   = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Wormhole lock: only a tail transfer or the watchdog frees it.
        release_g = (fire & tail_g) | wd_hit;
        if (release_g) begin
          grant_nxt = '0;
          sel_nxt   = '0;
          ptr_nxt   = ptr_inc;
          state_nxt = IDLE;
        end
      end
    endcase
  end

`ifdef ARB_WATCHDOG_EN
  logic [7:0] wd_cnt;

  assign wd_hit = (state == BUSY) && !fire
               && (wd_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt       <= '0;
      watchdog_err <= 1'b0;
    end else begin
      watchdog_err <= wd_hit;
      if (state != BUSY || fire || wd_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end
`else
  assign wd_hit       = 1'b0;
  assign watchdog_err = 1'b0;
`endif

  a_onehot: assert property (
    @(posedge clk) disable iff (rst)
    $onehot0(grant)
  );

  a_sel: assert property (
    @(posedge clk) disable iff (rst)
    (grant != '0) |-> (grant == (NUM_IN'(1) << xbar_sel))
  );

  a_idle: assert property (
    @(posedge clk) disable iff (rst)
    (state == IDLE) |-> (grant == '0 && xbar_sel == '0)
  );

endmodule
